multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for the multicycle `datapath`. A Moore-style FSM decodes the opcode/funct held in the instruction register. It drives every datapath control line per step (fetch, decode, execute, memory, writeback) and stalls on a memory-ready handshake. It also resolves branch conditions, flags illegal/halt opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; 0 forces state to FETCH and clears counter
- `opcode`  in  6  IR[31:26], stable from DECODE until next FETCH
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, valid combinationally in BRANCH
- `mem_ready`  in  1  memory completes access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls
- `ExtSel`  out  1  0 = sign-extend imm, 1 = zero-extend
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUSrcB`  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `ALUOp`  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
- `halted`  out  1  in HALT state
- `illegal`  out  1  in ILLEGAL state
- `retired`  out  CNT_W  instructions completed since reset

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000, slti 001010, andi 001100, ori 001101, halt 111111; anything else → ILLEGAL.
- R funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010; other funct → ILLEGAL from DECODE.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00. IRWrite and PCWrite are asserted only in the cycle with mem_ready=1, which exits to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target → ALUOut). Dispatch on opcode.
- MEM_ADDR (lw/sw): ALUSrcA=1, ALUSrcB=10, ADD, ExtSel=0. Next state is MEM_RD or MEM_WR.
- MEM_RD: IorD=1, MemRead=1. Hold until mem_ready, then MEM_WB. MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1.
- MEM_WR: IorD=1, MemWrite=1 held until mem_ready; the instruction retires on exit.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from funct. R_WB: RegDst=1, MemtoReg=0, RegWrite=1.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ExtSel=1 for andi/ori, else 0. ALUOp: ADD/SLT/AND/OR. I_WB: RegDst=0, MemtoReg=0, RegWrite=1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01. PCWriteCond = (beq&zero)|(bne&~zero), already resolved; the datapath PC enable is PCWrite|PCWriteCond.
- JUMP: PCSource=10, PCWrite=1.
- HALT/ILLEGAL: all enables 0; terminal until reset.
- Outputs not listed for a state are 0.

## Timing
- While reset=0: state=FETCH, retired=0, halted=illegal=0. Every write/read enable is forced 0 regardless of state. FETCH outputs begin in the first cycle after release.
- Outputs are combinational from state, plus opcode/funct/zero/mem_ready. No output register.
- Latency with mem_ready tied 1: lw 5, sw 4, R 4, I 4, beq/bne 3, j 3 cycles. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- MemRead/MemWrite stay high and the address stays stable across stall cycles. Only one memory access is outstanding.
- `retired` increments by 1 on the final cycle of each instruction (MEM_WB, MEM_WR exit, R_WB, I_WB, BRANCH, JUMP). It wraps at 2^CNT_W. halt/illegal do not count.
- Asserting reset mid-instruction abandons it; any pending RegWrite/MemWrite is suppressed immediately.

## Structure
- Package `ctrl_pkg`: state enum (FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, HALT, ILLEGAL), opcode/funct localparams, ALUOp codes, PCSource/ALUSrcB encodings.
- Sub-module `alu_control`: combinational funct/opcode → 4-bit ALUOp.
- Top: state register, next-state logic, output decode, retired counter.

## Test plan
- Reset release, mem_ready=1, add (funct 100000) → FETCH, DECODE, R_EXEC with ALUOp=0010, R_WB with RegWrite=1, RegDst=1; retired=1 after 4 cycles.
- lw, with mem_ready low 2 cycles in MEM_RD → MemRead=1, IorD=1 held 3 cycles; RegWrite/MemtoReg=1 on cycle 7; retired increments once.
- beq zero=1 → PCWriteCond=1, PCSource=01 in cycle 3. bne zero=1 → PCWriteCond=0. ori → ExtSel=1, ALUOp=0001.
- opcode 010000 → ILLEGAL, illegal=1, all enables 0 for 20 cycles. opcode 111111 → halted=1, retired unchanged.
- reset=0 asserted during MEM_WR with mem_ready=0 → MemWrite drops in same cycle; after release, FETCH and retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding, instruction field
// codes, ALU operation codes, mux select encodings and the packed control word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr, StRExec,
    StRWb, StIExec, StIWb, StBranch, StJump, StHalt, StIllegal
  } state_e;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpHalt = 6'b111111;

  // R-type funct, IR[5:0]
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic       ext_sel;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. The controller (master) receives instruction fields, the ALU
// zero flag and memory ready, and drives every datapath control plus status and the retired
// instruction count. The datapath side uses the slave modport.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             ALUSrcA;
  logic             RegWrite;
  logic             RegDst;
  logic             ExtSel;
  logic [1:0]       PCSource;
  logic [1:0]       ALUSrcB;
  logic [3:0]       ALUOp;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, ExtSel, PCSource, ALUSrcB, ALUOp, halted, illegal, retired
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
           RegWrite, RegDst, ExtSel, PCSource, ALUSrcB, ALUOp, halted, illegal, retired
  );
endinterface

// File: rtl/alu_control.sv
// ALU operation decode for the execute-type steps.
//   opcode, funct : instruction fields
//   alu_op        : operation for MEM_ADDR / R_EXEC / I_EXEC / BRANCH
//   funct_valid   : opcode is R-type and funct is a supported operation
module alu_control
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = AluAdd;
    funct_valid = 1'b0;
    case (opcode)
      OpR: begin
        funct_valid = 1'b1;
        case (funct)
          FnAdd:   alu_op = AluAdd;
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          FnOr:    alu_op = AluOr;
          FnNor:   alu_op = AluNor;
          FnSlt:   alu_op = AluSlt;
          default: funct_valid = 1'b0;
        endcase
      end
      OpBeq, OpBne: alu_op = AluSub;
      OpSlti:       alu_op = AluSlt;
      OpAndi:       alu_op = AluAnd;
      OpOri:        alu_op = AluOr;
      default:      alu_op = AluAdd;  // lw, sw, addi
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencing controller for the multicycle datapath.
//   clk   : all state on rising edge
//   reset : asynchronous, active-low; returns to FETCH, clears the retired count and
//           forces every output to 0 while low
//   bus   : master side of multicycle_control_if (instruction fields, zero, mem_ready in;
//           datapath controls, halted, illegal, retired out)
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             retire;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       exec_alu_op;
  logic             funct_valid;

  alu_control u_alu_control (
    .opcode      (bus.opcode),
    .funct       (bus.funct),
    .alu_op      (exec_alu_op),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpR:                            state_d = funct_valid ? StRExec : StIllegal;
          OpLw, OpSw:                     state_d = StMemAddr;
          OpBeq, OpBne:                   state_d = StBranch;
          OpJ:                            state_d = StJump;
          OpAddi, OpSlti, OpAndi, OpOri:  state_d = StIExec;
          OpHalt:                         state_d = StHalt;
          default:                        state_d = StIllegal;
        endcase
      end
      StMemAddr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StRExec:   state_d = StRWb;
      StRWb:     state_d = StFetch;
      StIExec:   state_d = StIWb;
      StIWb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StHalt:    state_d = StHalt;
      StIllegal: state_d = StIllegal;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    ctrl   = '0;
    retire = 1'b0;
    unique case (state_q)
      StFetch: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SrcBFour;
        ctrl.alu_op    = AluAdd;
        ctrl.pc_source = PcSrcAlu;
        // IR and PC update only on the cycle the instruction word arrives
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      StDecode: begin
        ctrl.alu_src_b = SrcBImmSh;  // speculative branch target into ALUOut
        ctrl.alu_op    = AluAdd;
      end
      StMemAddr: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.alu_op    = AluAdd;
      end
      StMemRd: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      StMemWb: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        retire          = 1'b1;
      end
      StMemWr: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        retire         = bus.mem_ready;
      end
      StRExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBReg;
        ctrl.alu_op    = exec_alu_op;
      end
      StRWb: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      StIExec: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SrcBImm;
        ctrl.ext_sel   = (bus.opcode == OpAndi) || (bus.opcode == OpOri);
        ctrl.alu_op    = exec_alu_op;
      end
      StIWb: begin
        ctrl.reg_write = 1'b1;
        retire         = 1'b1;
      end
      StBranch: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SrcBReg;
        ctrl.alu_op        = AluSub;
        ctrl.pc_source     = PcSrcAluOut;
        ctrl.pc_write_cond = ((bus.opcode == OpBeq) &&  bus.zero) ||
                             ((bus.opcode == OpBne) && !bus.zero);
        retire             = 1'b1;
      end
      StJump: begin
        ctrl.pc_source = PcSrcJump;
        ctrl.pc_write  = 1'b1;
        retire         = 1'b1;
      end
      StHalt:    ctrl.halted  = 1'b1;
      StIllegal: ctrl.illegal = 1'b1;
      default: ;
    endcase
    // Reset suppresses every output immediately, not just from the next edge
    if (!reset) begin
      ctrl   = '0;
      retire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.ExtSel      = ctrl.ext_sel;
  assign bus.PCSource    = ctrl.pc_source;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.halted      = ctrl.halted;
  assign bus.illegal     = ctrl.illegal;
  assign bus.retired     = cnt_q;

endmodule
